// File: rtl/branch_resolve_pkg.sv
// Shared defines for branch resolution: opcodes, funct3 branch conditions, FSM encoding, link increment.
package branch_resolve_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned FCNT_W = 4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] LINK_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_FLUSH = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolve_bxx_compare.sv
// Conditional-branch comparator: evaluates funct3 against the two forwarded operands.
module bxx_compare
    import branch_resolve_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1v == rs2v);
            F3_BNE:  taken = (rs1v != rs2v);
            F3_BLT:  taken = ($signed(rs1v) <  $signed(rs2v));
            F3_BGE:  taken = ($signed(rs1v) >= $signed(rs2v));
            F3_BLTU: taken = (rs1v <  rs2v);
            F3_BGEU: taken = (rs1v >= rs2v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: detects mispredicts, issues a fetch redirect, then flushes front-end.
// Optional performance counters enabled with BRANCH_PERF_CNT_EN.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            exe_valid,
    output logic            exe_ready,
    input  logic            exe_isbxx,
    input  logic            exe_isjal,
    input  logic            exe_isjalr,
    input  logic            exe_predict_taken,
    input  logic [XLEN-1:0] exe_pred_target,
    input  logic [XLEN-1:0] exe_pc,
    input  logic [F3_W-1:0] exe_funct3,
    input  logic [XLEN-1:0] exe_rs1v,
    input  logic [XLEN-1:0] exe_rs2v,
    input  logic [XLEN-1:0] exe_bxxoffset,
    input  logic [XLEN-1:0] exe_jalroffset,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush,
    output logic [XLEN-1:0] bxx_cnt,
    output logic [XLEN-1:0] mispred_cnt
);

    br_state_e         r_state;
    br_state_e         w_state_n;
    logic [FCNT_W-1:0] r_flush_cnt;
    logic [FCNT_W-1:0] w_flush_cnt_n;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [XLEN-1:0]   w_redirect_pc_n;
    logic              r_exe_ready;
    logic              r_redirect_valid;
    logic              r_flush;

    logic              w_resolve;
    logic              w_taken;
    logic [XLEN-1:0]   w_bxx_target;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_jalr_target;
    logic [XLEN-1:0]   w_target;
    logic              w_mispred;

    bxx_compare u_cmp (
        .funct3 (exe_funct3),
        .rs1v   (exe_rs1v),
        .rs2v   (exe_rs2v),
        .taken  (w_taken)
    );

    assign w_resolve     = exe_valid & r_exe_ready & (exe_isbxx | exe_isjal | exe_isjalr);
    assign w_bxx_target  = w_taken ? (exe_pc + exe_bxxoffset) : (exe_pc + LINK_INC);
    assign w_jalr_sum    = exe_rs1v + exe_jalroffset;
    assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_target      = exe_isbxx ? w_bxx_target : w_jalr_target;

    // jal targets are exact at fetch, so only bxx and jalr can mispredict
    always_comb begin
        w_mispred = 1'b0;
        if (exe_isbxx) begin
            w_mispred = (w_taken != exe_predict_taken);
        end else if (exe_isjalr) begin
            w_mispred = (w_jalr_target != exe_pred_target);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_flush_cnt   <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state       <= w_state_n;
            r_flush_cnt   <= w_flush_cnt_n;
            r_redirect_pc <= w_redirect_pc_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_flush_cnt_n   = r_flush_cnt;
        w_redirect_pc_n = r_redirect_pc;
        case (r_state)
            ST_IDLE: begin
                if (w_resolve && w_mispred) begin
                    w_state_n       = ST_REDIR;
                    w_redirect_pc_n = w_target;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    if (FLUSH_CYC == 0) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n     = ST_FLUSH;
                        w_flush_cnt_n = FCNT_W'(FLUSH_CYC);
                    end
                end
            end
            ST_FLUSH: begin
                w_flush_cnt_n = r_flush_cnt - FCNT_W'(1);
                if (r_flush_cnt <= FCNT_W'(1)) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // handshake outputs are flopped from the next state so they line up with r_state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exe_ready      <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
        end else begin
            r_exe_ready      <= (w_state_n == ST_IDLE);
            r_redirect_valid <= (w_state_n == ST_REDIR);
            r_flush          <= (w_state_n != ST_IDLE);
        end
    end

    assign exe_ready      = r_exe_ready;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;

`ifdef BRANCH_PERF_CNT_EN
    logic [XLEN-1:0] r_bxx_cnt;
    logic [XLEN-1:0] r_mispred_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bxx_cnt     <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && exe_isbxx) begin
                r_bxx_cnt <= r_bxx_cnt + XLEN'(1);
            end
            if (w_resolve && w_mispred) begin
                r_mispred_cnt <= r_mispred_cnt + XLEN'(1);
            end
        end
    end

    assign bxx_cnt     = r_bxx_cnt;
    assign mispred_cnt = r_mispred_cnt;
`else
    assign bxx_cnt     = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected redirect PCs queued at issue, checked by a monitor.
module tb_branch_resolve;

    localparam int unsigned FLUSH_CYC = 2;
`ifdef BRANCH_PERF_CNT_EN
    localparam logic PERF_EN = 1'b1;
`else
    localparam logic PERF_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        exe_valid;
    logic        exe_ready;
    logic        exe_isbxx;
    logic        exe_isjal;
    logic        exe_isjalr;
    logic        exe_predict_taken;
    logic [31:0] exe_pred_target;
    logic [31:0] exe_pc;
    logic [2:0]  exe_funct3;
    logic [31:0] exe_rs1v;
    logic [31:0] exe_rs2v;
    logic [31:0] exe_bxxoffset;
    logic [31:0] exe_jalroffset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic [31:0] bxx_cnt;
    logic [31:0] mispred_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cur = '0;
    logic        seen = 1'b0;
    logic [31:0] exp_bxx = '0;
    logic [31:0] exp_mis = '0;

    branch_resolve #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .exe_valid         (exe_valid),
        .exe_ready         (exe_ready),
        .exe_isbxx         (exe_isbxx),
        .exe_isjal         (exe_isjal),
        .exe_isjalr        (exe_isjalr),
        .exe_predict_taken (exe_predict_taken),
        .exe_pred_target   (exe_pred_target),
        .exe_pc            (exe_pc),
        .exe_funct3        (exe_funct3),
        .exe_rs1v          (exe_rs1v),
        .exe_rs2v          (exe_rs2v),
        .exe_bxxoffset     (exe_bxxoffset),
        .exe_jalroffset    (exe_jalroffset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready),
        .flush             (flush),
        .bxx_cnt           (bxx_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // monitor: each new redirect pops one expected PC; it must then hold while pending
    always @(negedge clk) begin
        if (redirect_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc);
                end else begin
                    exp_cur = exp_q.pop_front();
                    chk32("redirect_pc", redirect_pc, exp_cur);
                end
            end else begin
                chk32("redirect_pc_stable", redirect_pc, exp_cur);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic chk_cnt(input string tag);
        chk32({tag, "_bxx_cnt"}, bxx_cnt, exp_bxx);
        chk32({tag, "_mispred_cnt"}, mispred_cnt, exp_mis);
    endtask

    // called in the drive phase just after the accepting edge
    task automatic redirect_flow(input int stall);
        redirect_ready = (stall == 0);
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            chk1("redir_valid", redirect_valid, 1'b1);
            chk1("redir_flush", flush, 1'b1);
            chk1("redir_exe_ready", exe_ready, 1'b0);
            @(posedge clk); #1;
            redirect_ready = ((k + 1) == stall);
        end
        for (int j = 0; j < int'(FLUSH_CYC); j++) begin
            @(negedge clk);
            chk1("flush_valid", redirect_valid, 1'b0);
            chk1("flush_flush", flush, 1'b1);
            chk1("flush_exe_ready", exe_ready, 1'b0);
            @(posedge clk); #1;
        end
        exe_valid = 1'b0;
        @(negedge clk);
        chk1("idle_valid", redirect_valid, 1'b0);
        chk1("idle_flush", flush, 1'b0);
        chk1("idle_exe_ready", exe_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    // kind: 0 non-control, 1 bxx, 2 jal, 3 jalr
    task automatic resolve(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                           input logic [31:0] boff, input logic [31:0] joff, input logic pt,
                           input logic [31:0] ptgt, input logic mis, input logic [31:0] epc,
                           input int stall, input logic hold);
        exe_valid         = 1'b1;
        exe_isbxx         = (kind == 2'd1);
        exe_isjal         = (kind == 2'd2);
        exe_isjalr        = (kind == 2'd3);
        exe_funct3        = f3;
        exe_rs1v          = rs1;
        exe_rs2v          = rs2;
        exe_pc            = pc;
        exe_bxxoffset     = boff;
        exe_jalroffset    = joff;
        exe_predict_taken = pt;
        exe_pred_target   = ptgt;
        if (mis) exp_q.push_back(epc);
        if (kind == 2'd1) exp_bxx = exp_bxx + 32'(PERF_EN);
        if (mis) exp_mis = exp_mis + 32'(PERF_EN);
        @(negedge clk);
        chk1({tag, "_ready_before"}, exe_ready, 1'b1);
        @(posedge clk); #1;
        if (!(mis && hold)) exe_valid = 1'b0;
        if (mis) begin
            redirect_flow(stall);
        end else begin
            @(negedge clk);
            chk1({tag, "_no_redirect"}, redirect_valid, 1'b0);
            chk1({tag, "_no_flush"}, flush, 1'b0);
            chk1({tag, "_ready_after"}, exe_ready, 1'b1);
            @(posedge clk); #1;
        end
        exe_isbxx  = 1'b0;
        exe_isjal  = 1'b0;
        exe_isjalr = 1'b0;
        chk_cnt(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; exe_valid = 1'b0; exe_isbxx = 1'b0; exe_isjal = 1'b0; exe_isjalr = 1'b0;
        exe_predict_taken = 1'b0; exe_pred_target = '0; exe_pc = '0; exe_funct3 = '0;
        exe_rs1v = '0; exe_rs2v = '0; exe_bxxoffset = '0; exe_jalroffset = '0;
        redirect_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_exe_ready", exe_ready, 1'b1);
        chk_cnt("rst");
        rstn = 1'b1;

        resolve("beq",    2'd1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("blt",    2'd1, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'h120, 0, 1'b0);
        resolve("bltu",   2'd1, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h0, 1'b1, 32'h0, 1'b1, 32'h104, 3, 1'b1);
        resolve("jalr_ok",2'd3, 3'b000, 32'h2001, 32'h0, 32'h200, 32'h0, 32'h10, 1'b1, 32'h2010, 1'b0, 32'h0, 0, 1'b0);
        resolve("jalr_mp",2'd3, 3'b000, 32'h2001, 32'h0, 32'h200, 32'h0, 32'h10, 1'b1, 32'h2000, 1'b1, 32'h2010, 1, 1'b0);
        resolve("jal",    2'd2, 3'b000, 32'h0, 32'h0, 32'h300, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("alu",    2'd0, 3'b001, 32'h1, 32'h2, 32'h304, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("bne_wrap",2'd1,3'b001, 32'd3, 32'd3, 32'hFFFFFFFC, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 0, 1'b0);
        resolve("bge",    2'd1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h400, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("bgeu",   2'd1, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h400, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("f3_010", 2'd1, 3'b010, 32'd1, 32'd2, 32'h500, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 32'h504, 0, 1'b0);
        resolve("f3_011", 2'd1, 3'b011, 32'd1, 32'd2, 32'h500, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        resolve("beq_neg",2'd1, 3'b000, 32'd7, 32'd7, 32'h1000, 32'hFFFFFFF0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0FF0, 0, 1'b0);

        // reset asserted while a redirect is pending
        exe_valid = 1'b1; exe_isbxx = 1'b1; exe_funct3 = 3'b100;
        exe_rs1v = 32'hFFFFFFFF; exe_rs2v = 32'd1; exe_pc = 32'h600; exe_bxxoffset = 32'h20;
        exe_predict_taken = 1'b0;
        exp_q.push_back(32'h620);
        redirect_ready = 1'b0;
        @(negedge clk);
        chk1("rr_ready_before", exe_ready, 1'b1);
        @(posedge clk); #1;
        exe_valid = 1'b0; exe_isbxx = 1'b0;
        @(negedge clk);
        chk1("rr_redirect_valid", redirect_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk1("rr_valid_cleared", redirect_valid, 1'b0);
        chk1("rr_flush_cleared", flush, 1'b0);
        chk32("rr_pc_cleared", redirect_pc, 32'h0);
        chk1("rr_exe_ready", exe_ready, 1'b1);
        exp_bxx = '0;
        exp_mis = '0;
        chk_cnt("rr");
        @(posedge clk); #1;
        rstn = 1'b1;
        resolve("post_rst",2'd1,3'b000, 32'd9, 32'd9, 32'h700, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0);

`ifdef BRANCH_PERF_CNT_EN
        dut.r_mispred_cnt = 32'hFFFFFFFF;
        exp_mis = 32'hFFFFFFFF;
        resolve("wrap",   2'd1, 3'b001, 32'd1, 32'd2, 32'h800, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1, 32'h810, 0, 1'b0);
`endif

        chk32("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
